instr_fetch_unit: RTL

//  Multi-cycle fetch stage upstream of the ARM controller/datapath.
//  - Owns the PC and requests instruction words from instruction memory over a req/ready handshake.
//  - Latches each returned word into an instruction register, presents it as Instr to the controller and holds it until the datapath acks.
//  - On ack, advances PC to PC+4 or to the branch/write-PC target when the controller asserts PCSrc.

---
 rtl/arm_pkg.sv | 12 +
 rtl/pc_register.sv | 22 ++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared fetch-stage types and constants for the ARM core.
package arm_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] R15_OFFSET = 32'd8;

endpackage

// File: rtl/pc_register.sv
// Loadable register with async active-low reset; holds its value unless en is high.
// Latency: one clock from en/d to q; no handshake.
module pc_register #(
    parameter int          W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: requests a word at pc, holds it in Instr until the datapath acks, then advances pc.
// Latency: 1 fetch cycle plus memory wait states, then Instr held until instr_ack; stalls on imem_ready low.
module instr_fetch_unit
    import arm_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      Instr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus8,
    input  logic             instr_ack,
    input  logic             PCSrc,
    input  logic [31:0]      pc_result,
    output logic             misalign,
    output logic [CNT_W-1:0] instr_count
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         started;
    logic         fetch_take;
    logic         exec_done;
    logic [31:0]  pc_next;

    // Held low through the first edge after reset release so no request
    // appears in the reset cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_take  = 1'b0;
        exec_done   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req   = started;
                fetch_take = started && imem_ready;
                if (fetch_take) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                exec_done   = instr_ack;
                if (exec_done) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign pc_next = PCSrc ? {pc_result[31:2], 2'b00} : pc + PC_STEP;

    pc_register #(
        .W         (32),
        .RESET_VAL (PC_RESET)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (exec_done),
        .d   (pc_next),
        .q   (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Instr       <= '0;
            misalign    <= 1'b0;
            instr_count <= '0;
        end else begin
            if (fetch_take) begin
                Instr <= imem_rdata;
            end
            if (exec_done) begin
                instr_count <= instr_count + CNT_W'(1);
                if (PCSrc && (pc_result[1:0] != 2'b00)) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus8  = pc + R15_OFFSET;

endmodule
